// File: rtl/corevx_mmu_pkg.sv
// Shared types and widths for the corevx MMU page-table-walk path.
// Holds the arbiter state encoding and the PTW result payload.
package corevx_mmu_pkg;

    localparam int unsigned VPN_W         = 20;
    localparam int unsigned PPN_W         = 22;
    localparam int unsigned ACCESS_BITS_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                     pagefault;
        logic                     accessfault;
        logic [ACCESS_BITS_W-1:0] access_bits;
        logic [PPN_W-1:0]         ppn;
    } ptw_result_t;

endpackage

// File: rtl/corevx_rr_picker.sv
// Combinational round-robin picker: first set request bit after last_grant,
// wrapping around NUM_REQ.
module corevx_rr_picker #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned       off);
        int unsigned sum;
        sum = 32'(base) + off + 32'd1;
        return IDX_W'(sum % NUM_REQ);
    endfunction

    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!any && req[wrap_idx(last_grant, k)]) begin
                grant = wrap_idx(last_grant, k);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/corevx_ptw_arbiter.sv
// Shares one page-table walker between NUM_REQ MMU requesters with round-robin
// grant, snapshotting VPN and matp at grant time and routing the result back.
module corevx_ptw_arbiter
    import corevx_mmu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*VPN_W-1:0]   req_vaddr,
    output logic [NUM_REQ-1:0]         resp_done,
    output logic                       resp_pagefault,
    output logic                       resp_accessfault,
    output logic [ACCESS_BITS_W-1:0]   resp_access_bits,
    output logic [PPN_W-1:0]           resp_physical_address,
    input  logic                       csr_matp_mode,
    input  logic [PPN_W-1:0]           csr_matp_ppn,
    output logic                       ptw_resolve_request,
    input  logic                       ptw_resolve_ack,
    output logic [VPN_W-1:0]           ptw_virtual_address,
    input  logic                       ptw_resolve_done,
    input  logic                       ptw_resolve_pagefault,
    input  logic                       ptw_resolve_accessfault,
    input  logic [ACCESS_BITS_W-1:0]   ptw_resolve_access_bits,
    input  logic [PPN_W-1:0]           ptw_resolve_physical_address,
    output logic                       ptw_matp_mode,
    output logic [PPN_W-1:0]           ptw_matp_ppn
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   w_grant;
    logic               w_any;
    logic [VPN_W-1:0]   w_vaddr;
    logic [VPN_W-1:0]   r_vaddr;
    logic               r_matp_mode;
    logic [PPN_W-1:0]   r_matp_ppn;
    logic               r_ptw_req;
    ptw_result_t        r_result;

    corevx_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (r_grant),
        .grant      (w_grant),
        .any        (w_any)
    );

    always_comb begin
        w_vaddr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDX_W'(i)) begin
                w_vaddr = req_vaddr[i*VPN_W +: VPN_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)            w_state_nxt = ISSUE;
            ISSUE:   if (ptw_resolve_ack)  w_state_nxt = WAIT;
            WAIT:    if (ptw_resolve_done) w_state_nxt = RESPOND;
            RESPOND:                       w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // Grant snapshot is frozen from grant until the next IDLE decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant     <= IDX_W'(NUM_REQ - 1);
            r_vaddr     <= '0;
            r_matp_mode <= 1'b0;
            r_matp_ppn  <= '0;
            r_ptw_req   <= 1'b0;
            r_result    <= '0;
        end else begin
            r_ptw_req <= (w_state_nxt == ISSUE);
            if (r_state == IDLE && w_any) begin
                r_grant     <= w_grant;
                r_vaddr     <= w_vaddr;
                r_matp_mode <= csr_matp_mode;
                r_matp_ppn  <= csr_matp_ppn;
            end
            if (r_state == WAIT && ptw_resolve_done) begin
                r_result.pagefault   <= ptw_resolve_pagefault;
                r_result.accessfault <= ptw_resolve_accessfault;
                r_result.access_bits <= ptw_resolve_access_bits;
                r_result.ppn         <= ptw_resolve_physical_address;
            end
        end
    end

    // Pulse only if the requester is still waiting; a dropped request discards the result.
    always_comb begin
        resp_done = '0;
        if (r_state == RESPOND && req_valid[r_grant]) begin
            resp_done[r_grant] = 1'b1;
        end
    end

    assign resp_pagefault        = r_result.pagefault;
    assign resp_accessfault      = r_result.accessfault;
    assign resp_access_bits      = r_result.access_bits;
    assign resp_physical_address = r_result.ppn;
    assign ptw_resolve_request   = r_ptw_req;
    assign ptw_virtual_address   = r_vaddr;
    assign ptw_matp_mode         = r_matp_mode;
    assign ptw_matp_ppn          = r_matp_ppn;

endmodule

// File: tb/tb_corevx_ptw_arbiter.sv
// Directed bench for corevx_ptw_arbiter: arbitration order, handshake,
// matp snapshot, dropped requests and mid-walk reset.
module tb_corevx_ptw_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [39:0] req_vaddr;
    logic [1:0]  resp_done;
    logic        resp_pagefault;
    logic        resp_accessfault;
    logic [7:0]  resp_access_bits;
    logic [21:0] resp_physical_address;
    logic        csr_matp_mode;
    logic [21:0] csr_matp_ppn;
    logic        ptw_resolve_request;
    logic        ptw_resolve_ack;
    logic [19:0] ptw_virtual_address;
    logic        ptw_resolve_done;
    logic        ptw_resolve_pagefault;
    logic        ptw_resolve_accessfault;
    logic [7:0]  ptw_resolve_access_bits;
    logic [21:0] ptw_resolve_physical_address;
    logic        ptw_matp_mode;
    logic [21:0] ptw_matp_ppn;

    int checks   = 0;
    int failures = 0;

    corevx_ptw_arbiter #(.NUM_REQ(2)) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .req_valid                    (req_valid),
        .req_vaddr                    (req_vaddr),
        .resp_done                    (resp_done),
        .resp_pagefault               (resp_pagefault),
        .resp_accessfault             (resp_accessfault),
        .resp_access_bits             (resp_access_bits),
        .resp_physical_address        (resp_physical_address),
        .csr_matp_mode                (csr_matp_mode),
        .csr_matp_ppn                 (csr_matp_ppn),
        .ptw_resolve_request          (ptw_resolve_request),
        .ptw_resolve_ack              (ptw_resolve_ack),
        .ptw_virtual_address          (ptw_virtual_address),
        .ptw_resolve_done             (ptw_resolve_done),
        .ptw_resolve_pagefault        (ptw_resolve_pagefault),
        .ptw_resolve_accessfault      (ptw_resolve_accessfault),
        .ptw_resolve_access_bits      (ptw_resolve_access_bits),
        .ptw_resolve_physical_address (ptw_resolve_physical_address),
        .ptw_matp_mode                (ptw_matp_mode),
        .ptw_matp_ppn                 (ptw_matp_ppn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the ISSUE sample point; returns at the first WAIT sample point.
    task automatic issue(input string tag, input logic [19:0] exp_va);
        chk({tag, "_req"}, 32'(ptw_resolve_request), 32'd1);
        chk({tag, "_va"}, 32'(ptw_virtual_address), 32'(exp_va));
        ptw_resolve_ack = 1'b1;
        tick();
        ptw_resolve_ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(ptw_resolve_request), 32'd0);
    endtask

    // Drives the PTW done pulse; returns at the RESPOND sample point.
    task automatic complete(input logic pf, input logic af, input logic [7:0] bits,
                            input logic [21:0] pa);
        ptw_resolve_pagefault        = pf;
        ptw_resolve_accessfault      = af;
        ptw_resolve_access_bits      = bits;
        ptw_resolve_physical_address = pa;
        ptw_resolve_done             = 1'b1;
        tick();
        ptw_resolve_done             = 1'b0;
        ptw_resolve_pagefault        = 1'b0;
        ptw_resolve_accessfault      = 1'b0;
        ptw_resolve_access_bits      = 8'h00;
        ptw_resolve_physical_address = 22'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00;
        req_vaddr = 40'h0;
        csr_matp_mode = 1'b0;
        csr_matp_ppn = 22'h0;
        ptw_resolve_ack = 1'b0;
        ptw_resolve_done = 1'b0;
        ptw_resolve_pagefault = 1'b0;
        ptw_resolve_accessfault = 1'b0;
        ptw_resolve_access_bits = 8'h00;
        ptw_resolve_physical_address = 22'h0;
        tick();
        tick();
        chk("rst_done", 32'(resp_done), 32'd0);
        chk("rst_req", 32'(ptw_resolve_request), 32'd0);
        chk("rst_va", 32'(ptw_virtual_address), 32'd0);
        chk("rst_matp", 32'(ptw_matp_ppn), 32'd0);
        chk("rst_pa", 32'(resp_physical_address), 32'd0);
        rst_n = 1'b1;

        // Single request from requester 0, ISSUE held without ack.
        csr_matp_mode = 1'b1;
        csr_matp_ppn = 22'h1;
        req_vaddr[19:0] = 20'h12345;
        req_valid = 2'b01;
        tick();
        chk("t1_matp_ppn", 32'(ptw_matp_ppn), 32'h1);
        chk("t1_matp_mode", 32'(ptw_matp_mode), 32'd1);
        tick();
        chk("t1_req_held", 32'(ptw_resolve_request), 32'd1);
        issue("t1", 20'h12345);
        chk("t1_wait_nodone", 32'(resp_done), 32'd0);
        tick();
        complete(1'b0, 1'b0, 8'hCF, 22'h0ABCD);
        chk("t1_done", 32'(resp_done), 32'b01);
        chk("t1_pa", 32'(resp_physical_address), 32'h0ABCD);
        chk("t1_bits", 32'(resp_access_bits), 32'hCF);
        chk("t1_pf", 32'(resp_pagefault), 32'd0);
        chk("t1_af", 32'(resp_accessfault), 32'd0);
        req_valid = 2'b00;
        tick();
        chk("t1_done_once", 32'(resp_done), 32'd0);
        chk("t1_pa_hold", 32'(resp_physical_address), 32'h0ABCD);

        // Simultaneous requests right after reset: requester 0 first.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_vaddr = {20'h55555, 20'hAAAAA};
        req_valid = 2'b11;
        tick();
        issue("t2a", 20'hAAAAA);
        complete(1'b0, 1'b0, 8'h01, 22'h100);
        chk("t2a_done", 32'(resp_done), 32'b01);
        req_valid = 2'b10;
        tick();
        chk("t2_idle_nodone", 32'(resp_done), 32'd0);
        tick();
        issue("t2b", 20'h55555);
        complete(1'b1, 1'b0, 8'h02, 22'h200);
        chk("t2b_done", 32'(resp_done), 32'b10);
        chk("t2b_pf", 32'(resp_pagefault), 32'd1);

        // Both held: grants alternate 0,1,0,1.
        req_vaddr = {20'h22222, 20'h11111};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            issue($sformatf("t3_%0d", i), (i % 2 == 0) ? 20'h11111 : 20'h22222);
            complete(1'b0, 1'b0, 8'(i), 22'(i));
            chk($sformatf("t3_%0d_done", i), 32'(resp_done), (i % 2 == 0) ? 32'b01 : 32'b10);
        end

        // matp snapshot frozen across a mid-walk CSR change.
        req_valid = 2'b01;
        req_vaddr[19:0] = 20'h33333;
        csr_matp_mode = 1'b1;
        csr_matp_ppn = 22'h1;
        tick();
        tick();
        chk("t4_matp_grant", 32'(ptw_matp_ppn), 32'h1);
        issue("t4a", 20'h33333);
        csr_matp_ppn = 22'h2;
        csr_matp_mode = 1'b0;
        tick();
        chk("t4_matp_wait", 32'(ptw_matp_ppn), 32'h1);
        chk("t4_mode_wait", 32'(ptw_matp_mode), 32'd1);
        complete(1'b0, 1'b0, 8'h11, 22'h111);
        chk("t4a_done", 32'(resp_done), 32'b01);
        chk("t4_matp_resp", 32'(ptw_matp_ppn), 32'h1);
        tick();
        tick();
        chk("t4_matp_next", 32'(ptw_matp_ppn), 32'h2);
        chk("t4_mode_next", 32'(ptw_matp_mode), 32'd0);
        issue("t4b", 20'h33333);
        complete(1'b0, 1'b0, 8'h22, 22'h222);
        chk("t4b_regrant_done", 32'(resp_done), 32'b01);

        // Request dropped mid-walk: result discarded, no pulse.
        req_vaddr[19:0] = 20'h44444;
        tick();
        tick();
        issue("t5", 20'h44444);
        req_valid = 2'b00;
        tick();
        complete(1'b0, 1'b1, 8'h00, 22'h0);
        chk("t5_nodone", 32'(resp_done), 32'd0);
        chk("t5_af", 32'(resp_accessfault), 32'd1);
        req_vaddr[39:20] = 20'h66666;
        req_valid = 2'b10;
        tick();
        chk("t5_idle", 32'(ptw_resolve_request), 32'd0);
        tick();

        // Reset during WAIT, then normal service.
        issue("t6a", 20'h66666);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_req", 32'(ptw_resolve_request), 32'd0);
        chk("t6_rst_va", 32'(ptw_virtual_address), 32'd0);
        chk("t6_rst_matp", 32'(ptw_matp_ppn), 32'd0);
        chk("t6_rst_mode", 32'(ptw_matp_mode), 32'd0);
        chk("t6_rst_af", 32'(resp_accessfault), 32'd0);
        chk("t6_rst_done", 32'(resp_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_matp_new", 32'(ptw_matp_ppn), 32'h2);
        issue("t6b", 20'h66666);
        complete(1'b0, 1'b0, 8'h5A, 22'h3FFFF);
        chk("t6_done", 32'(resp_done), 32'b10);
        chk("t6_bits", 32'(resp_access_bits), 32'h5A);
        chk("t6_pa", 32'(resp_physical_address), 32'h3FFFF);
        req_valid = 2'b00;
        tick();
        chk("t6_done_once", 32'(resp_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
